raster_tile_sched: RTL and testbench

//   Frame-level sequencer for the tile rasterizer. Buffers one frame's triangle list,

---
 rtl/raster_tile_sched.sv | 223 ++++++++++++++++++++++
 tb/tb_raster_tile_sched.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raster_tile_sched.sv
// raster_tile_sched: buffers a frame's triangle list and sweeps every tile row-major.
// Define RASTER_SCHED_BBOX_CULL_EN to skip triangles whose bbox misses the tile.
module raster_tile_sched #(
  parameter int MAX_TRIS  = 64,
  parameter int TILE_COLS = 40,
  parameter int TILE_ROWS = 30,
  parameter int TILE_AREA = 256,
  localparam int CW = $clog2(MAX_TRIS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tri_wr_vld,
  output logic          tri_wr_rdy,
  input  logic [47:0]   tri_v0,
  input  logic [47:0]   tri_v1,
  input  logic [47:0]   tri_v2,
  input  logic [3:0]    tri_color,
  input  logic          frame_start,
  output logic          busy,
  output logic          frame_done,
  output logic          rast_vld,
  input  logic          rast_rdy,
  output logic [47:0]   rast_v0,
  output logic [47:0]   rast_v1,
  output logic [47:0]   rast_v2,
  output logic [15:0]   rast_meta,
  output logic          flush_req,
  input  logic          flush_ack,
  output logic [4:0]    flush_tile_x,
  output logic [4:0]    flush_tile_y,
`ifdef RASTER_SCHED_BBOX_CULL_EN
  output logic [15:0]   cull_count,
`endif
  output logic [CW-1:0] tri_count
);

  localparam int IW = (MAX_TRIS > 1) ? $clog2(MAX_TRIS) : 1;
  localparam int XW = ($clog2(TILE_COLS) > 5) ? $clog2(TILE_COLS) : 5;
  localparam int YW = ($clog2(TILE_ROWS) > 5) ? $clog2(TILE_ROWS) : 5;
  localparam int SW = (TILE_AREA > 1) ? $clog2(TILE_AREA) : 1;

  typedef enum logic [2:0] {
    IDLE, TILE, ISSUE, SWEEP, FLUSH, DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   tri_idx;
  logic [XW-1:0]   tile_x;
  logic [YW-1:0]   tile_y;
  logic [SW-1:0]   sweep;
  logic [147:0]    mem [MAX_TRIS];
  logic [IW-1:0]   sel_idx;
  logic [147:0]    sel;
  logic            sel_miss;
  logic            wr_ok;
  logic            adv;
  logic            last;
  logic            load;
  logic            to_flush;
  logic            last_tile;
  logic            last_col;

  assign tri_wr_rdy = (state == IDLE) &&
                      (tri_count < CW'(MAX_TRIS));
  assign wr_ok      = tri_wr_vld && tri_wr_rdy;

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[tri_count[IW-1:0]] <=
        {tri_v0, tri_v1, tri_v2, tri_color};
  end

  // Next entry to present: index 0 on tile entry, else the successor.
  assign sel_idx = (state == TILE) ? '0 : IW'(tri_idx + 1'b1);
  assign sel     = mem[sel_idx];

  assign last      = (tri_idx == tri_count - 1'b1);
  assign adv       = (state == ISSUE && !rast_vld) ||
                     (state == SWEEP && sweep == '0);
  assign load      = (state == TILE && tri_count != '0) ||
                     (adv && !last);
  assign to_flush  = (state == TILE && tri_count == '0) ||
                     (adv && last);
  assign last_col  = (tile_x == XW'(TILE_COLS - 1));
  assign last_tile = last_col &&
                     (tile_y == YW'(TILE_ROWS - 1));

`ifdef RASTER_SCHED_BBOX_CULL_EN
  function automatic logic signed [12:0] ipart(
    input logic [15:0] c
  );
    return 13'($signed(c[15:4]));
  endfunction

  logic signed [12:0] xa, xb, xc, ya, yb, yc;
  logic signed [12:0] xlo, xhi, ylo, yhi, tx, ty;

  always_comb begin
    xa = ipart(sel[147:132]);
    ya = ipart(sel[131:116]);
    xb = ipart(sel[99:84]);
    yb = ipart(sel[83:68]);
    xc = ipart(sel[51:36]);
    yc = ipart(sel[35:20]);
    xlo = xa;
    xhi = xa;
    ylo = ya;
    yhi = ya;
    if (xb < xlo) xlo = xb;
    if (xc < xlo) xlo = xc;
    if (xb > xhi) xhi = xb;
    if (xc > xhi) xhi = xc;
    if (yb < ylo) ylo = yb;
    if (yc < ylo) ylo = yc;
    if (yb > yhi) yhi = yb;
    if (yc > yhi) yhi = yc;
    tx = 13'({tile_x, 4'h0});
    ty = 13'({tile_y, 4'h0});
    sel_miss = (xhi < tx) || (xlo > tx + 13'sd15) ||
               (yhi < ty) || (ylo > ty + 13'sd15);
  end
`else
  assign sel_miss = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tri_count    <= '0;
      tri_idx      <= '0;
      tile_x       <= '0;
      tile_y       <= '0;
      sweep        <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      rast_vld     <= 1'b0;
      rast_v0      <= '0;
      rast_v1      <= '0;
      rast_v2      <= '0;
      rast_meta    <= '0;
      flush_req    <= 1'b0;
      flush_tile_x <= '0;
      flush_tile_y <= '0;
`ifdef RASTER_SCHED_BBOX_CULL_EN
      cull_count   <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (wr_ok) tri_count <= tri_count + 1'b1;
          if (frame_start) begin
            busy  <= 1'b1;
            state <= TILE;
`ifdef RASTER_SCHED_BBOX_CULL_EN
            cull_count <= '0;
`endif
          end
        end
        TILE: tri_idx <= '0;
        ISSUE: begin
          if (rast_vld && rast_rdy) begin
            rast_vld <= 1'b0;
            sweep    <= SW'(TILE_AREA - 1);
            state    <= SWEEP;
          end
        end
        SWEEP: begin
          if (sweep != '0) sweep <= sweep - 1'b1;
        end
        FLUSH: begin
          if (flush_ack) begin
            flush_req <= 1'b0;
            if (last_tile) begin
              tile_x     <= '0;
              tile_y     <= '0;
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              state <= TILE;
              if (last_col) begin
                tile_x <= '0;
                tile_y <= tile_y + 1'b1;
              end else begin
                tile_x <= tile_x + 1'b1;
              end
            end
          end
        end
        DONE: begin
          busy      <= 1'b0;
          tri_count <= '0;
          tile_x    <= '0;
          tile_y    <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (adv) tri_idx <= tri_idx + 1'b1;
`ifdef RASTER_SCHED_BBOX_CULL_EN
      if (state == ISSUE && !rast_vld)
        cull_count <= cull_count + 1'b1;
`endif
      // Culled entries enter ISSUE with vld low and are skipped next cycle.
      if (load) begin
        rast_v0   <= sel[147:100];
        rast_v1   <= sel[99:52];
        rast_v2   <= sel[51:4];
        rast_meta <= {sel[3:0], 2'b00,
                      tile_y[4:0], tile_x[4:0]};
        rast_vld  <= !sel_miss;
        state     <= ISSUE;
      end
      if (to_flush) begin
        flush_req    <= 1'b1;
        flush_tile_x <= tile_x[4:0];
        flush_tile_y <= tile_y[4:0];
        state        <= FLUSH;
      end
    end
  end

endmodule

// File: tb/tb_raster_tile_sched.sv
// tb_raster_tile_sched: directed checks on a 4x3 tile grid, 16-cycle sweep.
// Define RASTER_SCHED_BBOX_CULL_EN to also exercise bbox culling.
module tb_raster_tile_sched;

  localparam int NC = 4;
  localparam int NR = 3;
  localparam int NT = NC * NR;
  localparam int AREA = 16;

  logic        clk;
  logic        rst;
  logic        tri_wr_vld;
  logic        tri_wr_rdy;
  logic [47:0] tri_v0, tri_v1, tri_v2;
  logic [3:0]  tri_color;
  logic        frame_start;
  logic        busy;
  logic        frame_done;
  logic        rast_vld;
  logic        rast_rdy;
  logic [47:0] rast_v0, rast_v1, rast_v2;
  logic [15:0] rast_meta;
  logic        flush_req;
  logic        flush_ack;
  logic [4:0]  flush_tile_x, flush_tile_y;
  logic [6:0]  tri_count;
`ifdef RASTER_SCHED_BBOX_CULL_EN
  logic [15:0] cull_count;
`endif

  raster_tile_sched #(
    .MAX_TRIS(64), .TILE_COLS(NC),
    .TILE_ROWS(NR), .TILE_AREA(AREA)
  ) dut (
    .clk(clk), .rst(rst),
    .tri_wr_vld(tri_wr_vld), .tri_wr_rdy(tri_wr_rdy),
    .tri_v0(tri_v0), .tri_v1(tri_v1), .tri_v2(tri_v2),
    .tri_color(tri_color), .frame_start(frame_start),
    .busy(busy), .frame_done(frame_done),
    .rast_vld(rast_vld), .rast_rdy(rast_rdy),
    .rast_v0(rast_v0), .rast_v1(rast_v1),
    .rast_v2(rast_v2), .rast_meta(rast_meta),
    .flush_req(flush_req), .flush_ack(flush_ack),
    .flush_tile_x(flush_tile_x),
    .flush_tile_y(flush_tile_y),
`ifdef RASTER_SCHED_BBOX_CULL_EN
    .cull_count(cull_count),
`endif
    .tri_count(tri_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [15:0] rq_meta[$];
  logic [47:0] rq_v0[$];
  int          hs_cyc[$];
  int          fr_cyc[$];
  logic [9:0]  fq[$];
  int          done_n = 0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Flush unit model plus event log, all sampled on the falling edge.
  initial begin
    logic prev_fr;
    prev_fr = 1'b0;
    flush_ack = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rast_vld && rast_rdy) begin
        rq_meta.push_back(rast_meta);
        rq_v0.push_back(rast_v0);
        hs_cyc.push_back(cyc);
      end
      if (flush_req && !prev_fr) fr_cyc.push_back(cyc);
      prev_fr = flush_req;
      if (frame_done) done_n++;
      if (flush_req && !flush_ack) begin
        fq.push_back({flush_tile_y, flush_tile_x});
        flush_ack = 1'b1;
      end else begin
        flush_ack = 1'b0;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic put_tri(input logic [47:0] a,
                         input logic [47:0] b,
                         input logic [47:0] c,
                         input logic [3:0] col);
    tri_wr_vld = 1'b1;
    tri_v0 = a;
    tri_v1 = b;
    tri_v2 = c;
    tri_color = col;
    @(posedge clk);
    #1 tri_wr_vld = 1'b0;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
  endtask

  task automatic wait_done(input int lim, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk);
      #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_done"}, 64'(ok), 64'd1);
  endtask

  function automatic logic [9:0] tile_of(input int t);
    return {5'(t / NC), 5'(t % NC)};
  endfunction

  initial begin
    int rb, fb, hb, db, bad;
    logic [15:0] m;
    logic [47:0] v;
    bit seen;

    rst = 1'b1;
    tri_wr_vld = 1'b0;
    tri_v0 = '0;
    tri_v1 = '0;
    tri_v2 = '0;
    tri_color = '0;
    frame_start = 1'b0;
    rast_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_vld", 64'(rast_vld), 64'd0);
    chk("rst_flush", 64'(flush_req), 64'd0);
    chk("rst_done", 64'(frame_done), 64'd0);
    chk("rst_count", 64'(tri_count), 64'd0);
    chk("rst_wrrdy", 64'(tri_wr_rdy), 64'd1);
    chk("rst_meta", 64'(rast_meta), 64'd0);

    // Empty frame: every tile still flushed, nothing issued.
    rb = rq_meta.size();
    fb = fq.size();
    db = done_n;
    start_frame();
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_wrrdy", 64'(tri_wr_rdy), 64'd0);
    wait_done(500, "t1");
    chk("t1_nflush", 64'(fq.size() - fb), 64'(NT));
    for (int t = 0; t < NT; t++)
      chk($sformatf("t1_tile%0d", t),
          64'(fq[fb + t]), 64'(tile_of(t)));
    chk("t1_nrast", 64'(rq_meta.size() - rb), 64'd0);
    chk("t1_pulses", 64'(done_n - db), 64'd1);

    // One triangle issued once per tile; sweep spacing to flush.
    rast_rdy = 1'b1;
    put_tri(48'h0010_0020_0030, 48'h0040_0050_0060,
            48'h0070_0080_0090, 4'hA);
    chk("t2_count", 64'(tri_count), 64'd1);
    rb = rq_meta.size();
    hb = hs_cyc.size();
    fb = fr_cyc.size();
    db = done_n;
    start_frame();
    wait_done(2000, "t2");
    chk("t2_nrast", 64'(rq_meta.size() - rb), 64'(NT));
    chk("t2_meta00", 64'(rq_meta[rb]), 64'h0000_A000);
    chk("t2_meta32", 64'(rq_meta[rb + NT - 1]), 64'h0000_A043);
    chk("t2_v0", 64'(rq_v0[rb]), 64'h0010_0020_0030);
    chk("t2_gap", 64'(fr_cyc[fb] - hs_cyc[hb]), 64'(AREA + 1));
    chk("t2_pulses", 64'(done_n - db), 64'd1);

    // Full list; 65th write refused; per-tile order 0..63.
    for (int i = 0; i < 64; i++)
      put_tri(48'(i), 48'h0, 48'h0, 4'(i));
    chk("t3_count", 64'(tri_count), 64'd64);
    chk("t3_wrrdy", 64'(tri_wr_rdy), 64'd0);
    put_tri(48'hFFFF, 48'h0, 48'h0, 4'hF);
    chk("t3_count65", 64'(tri_count), 64'd64);
    rb = rq_meta.size();
    start_frame();
    wait_done(20000, "t3");
    chk("t3_nrast", 64'(rq_meta.size() - rb), 64'(64 * NT));
    bad = 0;
    for (int k = 0; k < 64 * NT; k++) begin
      if (rq_v0[rb + k] !== 48'(k % 64)) bad++;
      if (rq_meta[rb + k] !==
          {4'(k % 64), 2'b00, tile_of(k / 64)}) bad++;
    end
    chk("t3_order", 64'(bad), 64'd0);

    // Ready held low: request and payload stay put.
    rast_rdy = 1'b0;
    put_tri(48'h1234_5678_9ABC, 48'h0, 48'h0, 4'h5);
    rb = rq_meta.size();
    start_frame();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (rast_vld) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t4_vld", 64'(seen), 64'd1);
    m = rast_meta;
    v = rast_v0;
    chk("t4_meta", 64'(m), 64'h0000_5000);
    bad = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (!rast_vld || rast_meta !== m || rast_v0 !== v) bad++;
    end
    chk("t4_stable", 64'(bad), 64'd0);
    chk("t4_nohs", 64'(rq_meta.size() - rb), 64'd0);
    rast_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_vld_drop", 64'(rast_vld), 64'd0);
    chk("t4_onehs", 64'(rq_meta.size() - rb), 64'd1);
    wait_done(2000, "t4");

    // Reset mid-sweep of tile (2,0), then a fresh empty frame.
    put_tri(48'h0, 48'h0, 48'h0, 4'h3);
    rb = rq_meta.size();
    start_frame();
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (rq_meta.size() >= rb + 3) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t5_reach", 64'(seen), 64'd1);
    chk("t5_tile", 64'(rq_meta[rb + 2]), 64'h0000_3002);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_vld", 64'(rast_vld), 64'd0);
    chk("t5_flush", 64'(flush_req), 64'd0);
    chk("t5_count", 64'(tri_count), 64'd0);
    chk("t5_wrrdy", 64'(tri_wr_rdy), 64'd1);
    chk("t5_meta", 64'(rast_meta), 64'd0);
    rb = rq_meta.size();
    fb = fq.size();
    start_frame();
    wait_done(500, "t5");
    chk("t5_nflush", 64'(fq.size() - fb), 64'(NT));
    chk("t5_first", 64'(fq[fb]), 64'(tile_of(0)));
    chk("t5_second", 64'(fq[fb + 1]), 64'(tile_of(1)));
    chk("t5_nrast", 64'(rq_meta.size() - rb), 64'd0);

`ifdef RASTER_SCHED_BBOX_CULL_EN
    // Triangle covering pixels 0..8 only touches tile (0,0).
    put_tri({16'h0000, 16'h0000, 16'h0000},
            {16'h0080, 16'h0000, 16'h0000},
            {16'h0000, 16'h0080, 16'h0000}, 4'h7);
    rb = rq_meta.size();
    start_frame();
    wait_done(2000, "t6");
    chk("t6_nrast", 64'(rq_meta.size() - rb), 64'd1);
    chk("t6_meta", 64'(rq_meta[rb]), 64'h0000_7000);
    chk("t6_culled", 64'(cull_count), 64'(NT - 1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
